// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths and types for the fetch queue control slice
package fetch_queue_pkg;
    localparam int FQ_DEPTH   = 16;
    localparam int SKID_DEPTH = 2;
    typedef logic [$clog2(FQ_DEPTH)-1:0]     ptr_t;
    typedef logic [$clog2(FQ_DEPTH+3)-1:0]   cnt_t;
    typedef logic [$clog2(SKID_DEPTH+1)-1:0] sk_cnt_t;
endpackage

// File: rtl/fq_skid_buf.sv
// fq_skid_buf: 2-entry output FIFO absorbing RAM read latency
//   clk, rst, flush : clock, sync reset, sync clear
//   cap, din        : capture RAM read data into the tail
//   pop             : remove head (ignored when empty)
//   valid, dout     : head present / head word
//   cnt             : entries held (0..2)
module fq_skid_buf
    import fetch_queue_pkg::*;
#(
    parameter int Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   cap,
    input  logic [Word_Length-1:0] din,
    input  logic                   pop,
    output logic                   valid,
    output logic [Word_Length-1:0] dout,
    output sk_cnt_t                cnt
);
    logic [Word_Length-1:0] skid [SKID_DEPTH];
    logic                   take;
    sk_cnt_t                slot;

    assign valid = cnt != '0;
    assign dout  = skid[0];
    assign take  = pop && valid;
    // tail position after any concurrent pop has shifted the head out
    assign slot  = cnt - sk_cnt_t'(take);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt     <= '0;
            skid[0] <= '0;
            skid[1] <= '0;
        end else begin
            cnt <= cnt + sk_cnt_t'(cap) - sk_cnt_t'(take);
            if (take) skid[0] <= skid[1];
            if (cap) skid[slot[0]] <= din;
        end
    end
endmodule

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: FWFT fetch queue control around a 1-cycle-read dual-port RAM
//   clk, rst, flush              : clock, sync reset, sync flush
//   in_valid, in_ready, in_data  : push interface
//   out_valid, out_ready, out_data : pop interface (first-word-fall-through)
//   count                        : words held in RAM + in-flight read + skid
//   we, data_wr, addr_wr         : RAM write port
//   re, addr_rd, data_rd         : RAM read port, data_rd valid cycle after re
module fetch_queue_ctrl
    import fetch_queue_pkg::*;
#(
    parameter int Word_Length = 8,
    parameter int W_DEPTH     = FQ_DEPTH,
    parameter int CNT_W       = $clog2(W_DEPTH + 3)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Word_Length-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Word_Length-1:0]     out_data,
    output logic [CNT_W-1:0]           count,
    output logic                       we,
    output logic [Word_Length-1:0]     data_wr,
    output logic [$clog2(W_DEPTH)-1:0] addr_wr,
    output logic                       re,
    output logic [$clog2(W_DEPTH)-1:0] addr_rd,
    input  logic [Word_Length-1:0]     data_rd
);
    localparam int AW = $clog2(W_DEPTH);

    logic [AW-1:0]    wptr, rptr;
    logic [CNT_W-1:0] ram_cnt;
    logic             rd_pending, push, pop, sk_valid;
    sk_cnt_t          sk_cnt;

    assign in_ready  = !rst && !flush && ram_cnt != CNT_W'(W_DEPTH);
    assign push      = in_valid && in_ready;
    assign out_valid = !rst && sk_valid;
    assign pop       = out_valid && out_ready;
    // issue a read only if the skid has room once the pending read lands
    assign re        = !rst && !flush && ram_cnt != '0 &&
                       (3'(sk_cnt) + 3'(rd_pending)) < (3'(SKID_DEPTH) + 3'(pop));
    assign we        = push;
    assign data_wr   = in_data;
    assign addr_wr   = wptr;
    assign addr_rd   = rptr;
    assign count     = rst ? '0 : ram_cnt + CNT_W'(rd_pending) + CNT_W'(sk_cnt);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(re);
            ram_cnt    <= ram_cnt + CNT_W'(push) - CNT_W'(re);
            rd_pending <= re;
        end
    end

    fq_skid_buf #(.Word_Length(Word_Length)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .cap  (rd_pending),
        .din  (data_rd),
        .pop  (pop),
        .valid(sk_valid),
        .dout (out_data),
        .cnt  (sk_cnt)
    );
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: randomized scoreboard bench for fetch_queue_ctrl with a RAM model
module tb_fetch_queue_ctrl;
    import fetch_queue_pkg::*;

    localparam int WL = 8;
    localparam int D  = FQ_DEPTH;

    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [WL-1:0] in_data = '0;
    logic          in_ready, out_valid, we, re;
    logic [WL-1:0] out_data, data_wr, data_rd;
    cnt_t          count;
    ptr_t          addr_wr, addr_rd;
    logic [WL-1:0] mem [D];

    int            tests = 0, fails = 0;
    logic [WL-1:0] sb [$];
    logic [WL-1:0] exp_w;

    fetch_queue_ctrl #(.Word_Length(WL), .W_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .we(we), .data_wr(data_wr), .addr_wr(addr_wr),
        .re(re), .addr_rd(addr_rd), .data_rd(data_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[addr_wr] <= data_wr;
        if (re) data_rd <= mem[addr_rd];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if ({we, re, in_ready} !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d we=%b re=%b in_ready=%b required 0 0 0", c, we, re, in_ready);
            end
            step;
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        tests++;
        if (count !== '0) begin fails++; $display("FAIL reset_count got %0d required 0", count); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        step;
    endtask

    task automatic test_basic;
        logic [WL-1:0] w [3];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = k < 3;
            in_data  = k < 3 ? w[k] : 8'h00;
            #1;
            tests++;
            if (out_valid !== (k >= 3)) begin
                fails++; $display("FAIL basic_latency cyc=%0d out_valid=%b required %b", k, out_valid, k >= 3);
            end
            tests++;
            if (count !== cnt_t'(k < 3 ? k : 3)) begin
                fails++; $display("FAIL basic_count cyc=%0d got %0d required %0d", k, count, k < 3 ? k : 3);
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (out_valid !== (k < 3)) begin
                fails++; $display("FAIL basic_pop_valid cyc=%0d out_valid=%b required %b", k, out_valid, k < 3);
            end
            if (k < 3) begin
                tests++;
                if (out_data !== w[k]) begin
                    fails++; $display("FAIL basic_pop_data cyc=%0d got %h required %h", k, out_data, w[k]);
                end
                if (sb.size() > 0) exp_w = sb.pop_front();
            end
            step;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full;
        int  idx = 0;
        int  budget;
        logic seen = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = WL'(idx);
            #1;
            tests++;
            if (count !== cnt_t'(sb.size())) begin
                fails++; $display("FAIL full_count cyc=%0d got %0d required %0d", c, count, sb.size());
            end
            if (in_ready) begin sb.push_back(WL'(idx)); idx++; end
            step;
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if (idx != 18) begin fails++; $display("FAIL full_accepted got %0d required 18", idx); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b required 0", in_ready); end
        tests++;
        if (count !== cnt_t'(18)) begin fails++; $display("FAIL full_count_max got %0d required 18", count); end
        out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            fails++; $display("FAIL full_pop_one valid=%b data=%h required 1 00", out_valid, out_data);
        end
        if (sb.size() > 0) exp_w = sb.pop_front();
        step;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (in_ready) seen = 1'b1;
            step;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL full_ready_return in_ready stayed 0 required 1 within 2 cycles"); end
        out_ready = 1'b1;
        budget = 60;
        while (sb.size() > 0 && budget > 0) begin
            #1;
            tests++;
            if (count !== cnt_t'(sb.size())) begin
                fails++; $display("FAIL full_drain_count got %0d required %0d", count, sb.size());
            end
            if (out_valid) begin
                exp_w = sb.pop_front();
                tests++;
                if (out_data !== exp_w) begin
                    fails++; $display("FAIL full_drain_data got %h required %h", out_data, exp_w);
                end
            end
            budget--;
            step;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL full_drain_timeout left %0d words required 0", sb.size()); sb.delete();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream;
        int idx = 0, got = 0, first = -1, last = -1, maxc = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_valid = idx < 40;
            in_data  = WL'(idx);
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            tests++;
            if (count !== cnt_t'(sb.size())) begin
                fails++; $display("FAIL stream_count cyc=%0d got %0d required %0d", c, count, sb.size());
            end
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL stream_spurious cyc=%0d out_valid=1 required 0", c);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        fails++; $display("FAIL stream_data cyc=%0d got %h required %h", c, out_data, exp_w);
                    end
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); idx++; end
            step;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (got != 40) begin fails++; $display("FAIL stream_words got %0d required 40", got); end
        tests++;
        if (first != 3) begin fails++; $display("FAIL stream_latency first pop cyc %0d required 3", first); end
        tests++;
        if (last != 42) begin fails++; $display("FAIL stream_rate last pop cyc %0d required 42", last); end
        tests++;
        if (maxc > 3) begin fails++; $display("FAIL stream_max_count got %0d required <=3", maxc); end
        sb.delete();
    endtask

    task automatic test_flush;
        int budget = 8;
        logic found = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = WL'(8'h50 + c);
            #1;
            if (in_ready) sb.push_back(in_data);
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h50) begin
            fails++; $display("FAIL flush_pre_pop valid=%b data=%h required 1 50", out_valid, out_data);
        end
        step;
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        tests++;
        if ({in_ready, we, re} !== 3'b000) begin
            fails++; $display("FAIL flush_gating in_ready=%b we=%b re=%b required 0 0 0", in_ready, we, re);
        end
        sb.delete();
        step;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++;
            if (out_valid !== 1'b0 || count !== '0) begin
                fails++; $display("FAIL flush_clear cyc=%0d out_valid=%b count=%0d required 0 0", c, out_valid, count);
            end
            step;
        end
        in_valid = 1'b1; in_data = 8'hAA;
        #1;
        if (in_ready) sb.push_back(in_data);
        step;
        in_valid = 1'b0; out_ready = 1'b1;
        while (!found && budget > 0) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                tests++;
                if (out_data !== 8'hAA) begin
                    fails++; $display("FAIL flush_first_word got %h required aa", out_data);
                end
            end
            budget--;
            step;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL flush_first_timeout out_valid stayed 0 required 1"); end
        #1;
        tests++;
        if (count !== '0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_after_pop count=%0d out_valid=%b required 0 0", count, out_valid);
        end
        step;
        out_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_random;
        int pushed = 0, popped = 0, cyc = 0;
        while ((pushed < 1000 || sb.size() > 0) && cyc < 20000) begin
            in_valid  = pushed < 1000 && $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = WL'($urandom);
            #1;
            tests++;
            if (count !== cnt_t'(sb.size())) begin
                fails++; $display("FAIL rand_count cyc=%0d got %0d required %0d", cyc, count, sb.size());
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL rand_dup cyc=%0d popped %h from empty model", cyc, out_data);
                end else begin
                    exp_w = sb.pop_front();
                    popped++;
                    if (out_data !== exp_w) begin
                        fails++; $display("FAIL rand_data cyc=%0d got %h required %h", cyc, out_data, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) begin sb.push_back(in_data); pushed++; end
            cyc++;
            step;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (popped != 1000) begin
            fails++; $display("FAIL rand_total popped %0d required 1000", popped);
        end
        sb.delete();
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_full;
        test_stream;
        test_flush;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
